// File: rtl/adc_frame_serializer.sv
// Two-entry ping-pong frame buffer streamed as {header, NCH samples} words over valid/ready.
// Define ADC_FRAME_TRAILER_EN to append a per-frame XOR checksum word (DOUT_LAST moves to it).
module adc_frame_serializer #(
  parameter int unsigned NCH     = 20,
  parameter logic [3:0]  HDR_TAG = 4'hA
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             ENABLE,
  input  logic [NCH*16-1:0] DIN,
  input  logic             DIN_VALID,
  output logic [15:0]      DOUT,
  output logic             DOUT_VALID,
  input  logic             DOUT_READY,
  output logic             DOUT_LAST,
  output logic [11:0]      FRAME_CNT,
  output logic [15:0]      OVERFLOW_CNT,
  output logic             BUSY
);

  localparam int unsigned   IW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

`ifdef ADC_FRAME_TRAILER_EN
  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA, S_TRAILER} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA} state_t;
`endif

  state_t        r_state;
  logic [15:0]   r_buf [2][NCH];
  logic [11:0]   r_tag [2];
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_occ;
  logic [IW-1:0] r_idx;
  logic [11:0]   r_frame_cnt;
  logic [15:0]   r_ovf;

  logic          w_fire;
  logic          w_cap;
  logic          w_pop;
  logic          w_push;
  logic          w_next_pend;
  logic [11:0]   w_next_tag;

`ifdef ADC_FRAME_TRAILER_EN
  logic [15:0]   r_xor [2];
  logic [15:0]   w_din_xor;

  always_comb begin
    w_din_xor = '0;
    for (int unsigned i = 0; i < NCH; i++) w_din_xor = w_din_xor ^ DIN[16*i +: 16];
  end

  assign w_pop = w_fire & (r_state == S_TRAILER);
`else
  assign w_pop = w_fire & (r_state == S_DATA) & (r_idx == LAST_IDX);
`endif

  assign w_fire = DOUT_VALID & DOUT_READY;
  assign w_cap  = DIN_VALID & ENABLE;
  // A full buffer still accepts when the slot being read is released this same cycle.
  assign w_push = w_cap & ((r_occ != 2'd2) | w_pop);
  // After a pop, something remains if the buffer was full or a frame arrives now.
  assign w_next_pend = (r_occ == 2'd2) | w_push;
  assign w_next_tag  = (r_occ == 2'd2) ? r_tag[~r_rptr] : r_frame_cnt;

  assign FRAME_CNT    = r_frame_cnt;
  assign OVERFLOW_CNT = r_ovf;
  assign BUSY         = (r_occ != 2'd0) | (r_state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (w_push) begin
      for (int unsigned i = 0; i < NCH; i++) r_buf[r_wptr][i] <= DIN[16*i +: 16];
      r_tag[r_wptr] <= r_frame_cnt;
`ifdef ADC_FRAME_TRAILER_EN
      r_xor[r_wptr] <= w_din_xor;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_occ       <= '0;
      r_frame_cnt <= '0;
      r_ovf       <= '0;
      DOUT        <= '0;
      DOUT_VALID  <= 1'b0;
      DOUT_LAST   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
      if (w_cap) begin
        r_frame_cnt <= r_frame_cnt + 12'd1;
        if (!w_push && (r_ovf != '1)) r_ovf <= r_ovf + 16'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (r_occ != 2'd0) begin
            r_state    <= S_HEADER;
            DOUT       <= {HDR_TAG, r_tag[r_rptr]};
            DOUT_VALID <= 1'b1;
            DOUT_LAST  <= 1'b0;
          end
        end
        S_HEADER: begin
          if (w_fire) begin
            r_state <= S_DATA;
            r_idx   <= '0;
            DOUT    <= r_buf[r_rptr][0];
`ifdef ADC_FRAME_TRAILER_EN
            DOUT_LAST <= 1'b0;
`else
            DOUT_LAST <= (LAST_IDX == '0);
`endif
          end
        end
        S_DATA: begin
          if (w_fire) begin
            if (r_idx != LAST_IDX) begin
              r_idx <= r_idx + 1'b1;
              DOUT  <= r_buf[r_rptr][r_idx + 1'b1];
`ifndef ADC_FRAME_TRAILER_EN
              DOUT_LAST <= (r_idx + 1'b1 == LAST_IDX);
`endif
            end
`ifdef ADC_FRAME_TRAILER_EN
            else begin
              r_state   <= S_TRAILER;
              DOUT      <= r_xor[r_rptr];
              DOUT_LAST <= 1'b1;
            end
`endif
          end
        end
`ifdef ADC_FRAME_TRAILER_EN
        S_TRAILER: ;
`endif
        default: r_state <= S_IDLE;
      endcase

      // Frame completion overrides the per-state update so the next header follows with no gap.
      if (w_pop) begin
        if (w_next_pend) begin
          r_state    <= S_HEADER;
          DOUT       <= {HDR_TAG, w_next_tag};
          DOUT_VALID <= 1'b1;
          DOUT_LAST  <= 1'b0;
        end else begin
          r_state    <= S_IDLE;
          DOUT       <= '0;
          DOUT_VALID <= 1'b0;
          DOUT_LAST  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_serializer.sv
// Scoreboard bench for adc_frame_serializer (NCH=4): transaction-level buffer model feeds an expected-word queue.
module tb_adc_frame_serializer;

  localparam int NCH = 4;
`ifdef ADC_FRAME_TRAILER_EN
  localparam int WPF = NCH + 2;
`else
  localparam int WPF = NCH + 1;
`endif

  logic              CLK;
  logic              RESET_N;
  logic              ENABLE;
  logic [NCH*16-1:0] DIN;
  logic              DIN_VALID;
  logic [15:0]       DOUT;
  logic              DOUT_VALID;
  logic              DOUT_READY;
  logic              DOUT_LAST;
  logic [11:0]       FRAME_CNT;
  logic [15:0]       OVERFLOW_CNT;
  logic              BUSY;

  adc_frame_serializer #(.NCH(NCH), .HDR_TAG(4'hA)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY), .DOUT_LAST(DOUT_LAST),
    .FRAME_CNT(FRAME_CNT), .OVERFLOW_CNT(OVERFLOW_CNT), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct { logic [15:0] w; bit last; } exp_t;
  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          accepted;
  int          delivered;
  logic [11:0] m_fcnt;
  logic [15:0] m_ovf;
  bit          hold_v;
  logic [15:0] hold_w;
  bit          hold_l;
  bit          coincide_hit;
  int          ready_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    accepted  = 0;
    delivered = 0;
    m_fcnt    = '0;
    m_ovf     = '0;
    hold_v    = 1'b0;
  endfunction

  always @(posedge CLK) begin
    #1;
    case (ready_mode)
      0:       DOUT_READY = 1'b0;
      1:       DOUT_READY = 1'b1;
      default: DOUT_READY = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compares each accepted word with the queue head and checks stall stability.
  // Model: decides accept/drop for a capture at the coming edge from frames still undelivered.
  always @(negedge CLK) begin : mon
    bit          final_now;
    exp_t        e;
    logic [15:0] x;
    int          inflight;
    final_now = 1'b0;
    if (RESET_N) begin
      if (DOUT_VALID) begin
        if (hold_v) chk("hold_word", {15'b0, DOUT_LAST, DOUT}, {15'b0, hold_l, hold_w});
        if (DOUT_READY) begin
          hold_v = 1'b0;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h expected none", DOUT);
          end else begin
            e = q.pop_front();
            chk("word", {15'b0, DOUT_LAST, DOUT}, {15'b0, e.last, e.w});
            if (e.last) begin
              delivered++;
              final_now = 1'b1;
            end
          end
        end else begin
          hold_v = 1'b1;
          hold_w = DOUT;
          hold_l = DOUT_LAST;
        end
      end else if (hold_v) begin
        chk("hold_valid", {31'b0, DOUT_VALID}, 32'd1);
        hold_v = 1'b0;
      end

      if (DIN_VALID && ENABLE) begin
        inflight = accepted - delivered;
        if (inflight < 2) begin
          if (final_now && inflight == 1) coincide_hit = 1'b1;
          q.push_back('{w: {4'hA, m_fcnt}, last: 1'b0});
          x = '0;
          for (int c = 0; c < NCH; c++) begin
            x = x ^ DIN[16*c +: 16];
`ifdef ADC_FRAME_TRAILER_EN
            q.push_back('{w: DIN[16*c +: 16], last: 1'b0});
`else
            q.push_back('{w: DIN[16*c +: 16], last: (c == NCH - 1)});
`endif
          end
`ifdef ADC_FRAME_TRAILER_EN
          q.push_back('{w: x, last: 1'b1});
`endif
          accepted++;
        end else if (m_ovf != 16'hFFFF) begin
          m_ovf = m_ovf + 16'd1;
        end
        m_fcnt = m_fcnt + 12'd1;
      end
    end
  end

  task automatic pulse(input logic [63:0] d);
    #1;
    DIN       = d;
    DIN_VALID = 1'b1;
    @(posedge CLK);
    #1;
    DIN_VALID = 1'b0;
  endtask

  task automatic reset_dut();
    RESET_N = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    ready_mode = 1;
    while ((q.size() != 0 || BUSY) && n < 1000) begin
      @(posedge CLK);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, n);
    end
    @(posedge CLK);
    #2;
    chk({name, "_sb_empty"}, q.size(), 32'd0);
    chk({name, "_busy"}, {31'b0, BUSY}, 32'd0);
    chk({name, "_valid"}, {31'b0, DOUT_VALID}, 32'd0);
    chk({name, "_frame_cnt"}, {20'b0, FRAME_CNT}, {20'b0, m_fcnt});
    chk({name, "_ovf_cnt"}, {16'b0, OVERFLOW_CNT}, {16'b0, m_ovf});
  endtask

  initial begin : stim
    int nv;
    RESET_N   = 1'b0;
    ENABLE    = 1'b1;
    DIN       = '0;
    DIN_VALID = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_dout", {16'b0, DOUT}, 32'd0);
    chk("rst_valid", {31'b0, DOUT_VALID}, 32'd0);
    chk("rst_last", {31'b0, DOUT_LAST}, 32'd0);
    chk("rst_frame_cnt", {20'b0, FRAME_CNT}, 32'd0);
    chk("rst_ovf_cnt", {16'b0, OVERFLOW_CNT}, 32'd0);
    chk("rst_busy", {31'b0, BUSY}, 32'd0);
    RESET_N = 1'b1;

    // Single frame and capture-to-header latency
    ready_mode = 1;
    @(posedge CLK);
    pulse(64'h0004_0003_0002_0001);
    chk("lat_n1_valid", {31'b0, DOUT_VALID}, 32'd0);
    @(posedge CLK);
    #1;
    chk("lat_n2_valid", {31'b0, DOUT_VALID}, 32'd1);
    chk("lat_n2_header", {16'b0, DOUT}, 32'h0000_A000);
    chk("lat_n2_busy", {31'b0, BUSY}, 32'd1);
    drain("single");

    // Overflow: three pulses with the consumer stalled, then back-to-back drain
    reset_dut();
    ready_mode = 0;
    @(posedge CLK);
    pulse(64'h1111_2222_3333_4444);
    @(posedge CLK);
    pulse(64'h5555_6666_7777_8888);
    @(posedge CLK);
    pulse(64'h9999_AAAA_BBBB_CCCC);
    @(posedge CLK);
    #2;
    chk("ovf_frame_cnt", {20'b0, FRAME_CNT}, 32'd3);
    chk("ovf_ovf_cnt", {16'b0, OVERFLOW_CNT}, 32'd1);
    @(posedge CLK);
    ready_mode = 1;
    nv = 0;
    for (int i = 0; i < 2 * WPF; i++) begin
      @(negedge CLK);
      if (DOUT_VALID) nv++;
    end
    chk("no_gap_valid_cycles", nv, 2 * WPF);
    drain("overflow");

    // Full buffer with a new frame arriving on the final-word pop
    reset_dut();
    ready_mode = 0;
    coincide_hit = 1'b0;
    @(posedge CLK);
    pulse(64'h0A0A_0B0B_0C0C_0D0D);
    @(posedge CLK);
    pulse(64'h1234_5678_9ABC_DEF0);
    @(posedge CLK);
    ready_mode = 1;
    repeat (WPF - 1) @(posedge CLK);
    pulse(64'hFEDC_BA98_7654_3210);
    drain("fullpop");
    chk("fullpop_coincide", {31'b0, coincide_hit}, 32'd1);
    chk("fullpop_ovf_cnt", {16'b0, OVERFLOW_CNT}, 32'd0);
    chk("fullpop_frame_cnt", {20'b0, FRAME_CNT}, 32'd3);

    // ENABLE low: pulses ignored
    @(posedge CLK);
    ENABLE = 1'b0;
    pulse(64'h0001_0001_0001_0001);
    @(posedge CLK);
    pulse(64'h0002_0002_0002_0002);
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (DOUT_VALID) nv++;
    end
    chk("dis_no_output", nv, 0);
    chk("dis_frame_cnt", {20'b0, FRAME_CNT}, 32'd3);
    chk("dis_ovf_cnt", {16'b0, OVERFLOW_CNT}, 32'd0);
    ENABLE = 1'b1;

    // Randomized frames, enable and consumer backpressure
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      @(posedge CLK);
      #1;
      ENABLE    = ($urandom_range(0, 7) != 0);
      DIN       = {$urandom, $urandom};
      DIN_VALID = ($urandom_range(0, 4) == 0);
    end
    @(posedge CLK);
    #1;
    DIN_VALID = 1'b0;
    ENABLE    = 1'b1;
    drain("random");

    // Reset asserted while a frame is mid-stream
    @(posedge CLK);
    pulse(64'h0DDD_0CCC_0BBB_0AAA);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk("pre_rst_data0", {16'b0, DOUT}, 32'h0000_0AAA);
    #2;
    RESET_N = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_valid", {31'b0, DOUT_VALID}, 32'd0);
    chk("rst_mid_last", {31'b0, DOUT_LAST}, 32'd0);
    chk("rst_mid_busy", {31'b0, BUSY}, 32'd0);
    chk("rst_mid_frame_cnt", {20'b0, FRAME_CNT}, 32'd0);
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    @(posedge CLK);
    pulse(64'h0040_0030_0020_0010);
    @(posedge CLK);
    #1;
    chk("post_rst_header", {16'b0, DOUT}, 32'h0000_A000);
    drain("postreset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adc_frame_serializer.md
Name: adc_frame_serializer

Overview:
Downstream consumer of the ADC conversion/SIPO stage. Captures each parallel frame of NCH 16-bit samples, qualified by a one-cycle valid pulse, into a two-entry frame buffer. Emits the buffered frames as a 16-bit word stream with a valid/ready handshake toward the readout FIFO, prefixed by a header carrying a frame counter. Counts frames dropped because the buffer is full.

Parameters:
NCH, 20, number of ADC channels per frame (1..255)
HDR_TAG, 4'hA, upper nibble of the header word

Ports:
CLK  input  1  system clock; all logic is synchronous to it
RESET_N  input  1  asynchronous, active-low reset
ENABLE  input  1  high: accept frames; low: ignore DIN_VALID
DIN  input  NCH*16  parallel frame; channel i occupies bits [16*i+15:16*i]
DIN_VALID  input  1  one-cycle pulse; DIN is valid in this cycle
DOUT  output  16  stream word
DOUT_VALID  output  1  DOUT holds a valid word
DOUT_READY  input  1  consumer accepts the word when DOUT_VALID & DOUT_READY
DOUT_LAST  output  1  high on the final word of a frame
FRAME_CNT  output  12  frames seen while ENABLE was high (accepted + dropped), wraps
OVERFLOW_CNT  output  16  dropped frames, saturates at 16'hFFFF
BUSY  output  1  buffer non-empty or frame in transmission

Behaviour:
- Interface: one clock (CLK). Reset is asynchronous and active-low (RESET_N).
- Reset values: DOUT=0, DOUT_VALID=0, DOUT_LAST=0, FRAME_CNT=0, OVERFLOW_CNT=0, BUSY=0, buffer empty, FSM in IDLE. Assertion mid-frame aborts the frame immediately. After deassertion the first frame starts clean with header count 0.
- Buffer: 2-entry ping-pong, with write pointer, read pointer and 2-bit occupancy.
- Capture: on DIN_VALID & ENABLE:
  - If occupancy<2, or the final word of the frame being read is popped in the same cycle, the frame is written and tagged with the current FRAME_CNT.
  - Otherwise the frame is dropped and OVERFLOW_CNT increments (saturating).
  - In both cases FRAME_CNT increments (mod 4096).
- DIN_VALID with ENABLE low: no effect on buffer or counters.
- FSM:
  - IDLE: if occupancy>0, go to HEADER next cycle.
  - HEADER: DOUT={HDR_TAG, tag[11:0]}. On handshake go to DATA with channel index 0.
  - DATA: DOUT=channel[idx]. On handshake, idx increments. On idx==NCH-1, pop the entry; go to HEADER if another entry is pending, else IDLE.
- Latency: a frame captured in cycle N into an empty, idle block presents its header with DOUT_VALID=1 in cycle N+2.
- Back-to-back buffered frames stream with no idle cycle between the last word and the next header.
- Handshake:
  - Once DOUT_VALID is asserted, DOUT, DOUT_LAST and DOUT_VALID are held stable until accepted.
  - DOUT_VALID never depends combinationally on DOUT_READY.
  - Words per frame: NCH+1 (NCH+2 with the trailer).
- DOUT_LAST is high only on the final word of a frame.
- ENABLE deassertion never truncates a frame already in the buffer; buffered frames drain normally.
- BUSY = (occupancy!=0) | (state!=IDLE).

Optional Feature:
- Macro: ADC_FRAME_TRAILER_EN.
- Defined: after channel NCH-1 the FSM enters TRAILER and emits one word equal to the XOR of the NCH samples of that frame. DOUT_LAST moves to the trailer word. The XOR is computed at capture and stored with the buffer entry.
- Undefined: no TRAILER state and no stored checksum; DOUT_LAST is on channel NCH-1.

Test Plan (bench uses NCH=4, trailer disabled unless noted):
- Single frame, DIN={16'h0004,16'h0003,16'h0002,16'h0001}, DOUT_READY=1 -> words A000,0001,0002,0003,0004; LAST on 0004; header appears 2 cycles after pulse; BUSY drops after last word.
- Three pulses 1 cycle apart, DOUT_READY=0 -> third dropped, OVERFLOW_CNT=1, FRAME_CNT=3. After READY=1, two frames with headers A000 then A001, no gap between them.
- Random DOUT_READY toggling -> DOUT held stable while VALID & !READY; word order and content match the scoreboard.
- Buffer full, new pulse in the same cycle as the final-word pop -> frame accepted, OVERFLOW_CNT unchanged.
- ENABLE=0 pulses -> no output, counters unchanged. RESET_N low mid-DATA -> DOUT_VALID=0 immediately; after release the next frame's header is A000.
- ADC_FRAME_TRAILER_EN defined, samples 1,2,3,4 -> trailer word 0004 (1^2^3^4); LAST on the trailer.
